// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the asynchronous SRAM controller.
//   state_e      : controller FSM states
//   lanes_f      : byte-lane count for a given data width
//   cnt_width_f  : wait-counter width sized to the longest programmed wait
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_TURN,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_e;

  function automatic int unsigned lanes_f(input int unsigned dw);
    return dw / 8;
  endfunction

  // clog2(max(rw, ww, tw) + 1), never less than one bit
  function automatic int unsigned cnt_width_f(input int unsigned rw,
                                              input int unsigned ww,
                                              input int unsigned tw);
    int unsigned m;
    m = rw;
    if (ww > m) m = ww;
    if (tw > m) m = tw;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_dq_pad.sv
// Bidirectional SRAM data pad: registered output enable and write data
// driving a tri-state buffer, plus a registered sample of the pin data.
//   clk, reset_n : clock, async active-low reset
//   i_oe_d       : next-cycle output enable
//   i_load       : capture i_wdata as the data to drive
//   i_wdata      : write data
//   i_sample     : capture io_dq into o_rdata at this edge
//   o_rdata      : sampled read data (held between samples)
//   io_dq        : SRAM data pins
module sram_dq_pad #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_oe_d,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_sample,
  output logic [DATA_WIDTH-1:0] o_rdata,
  inout  wire  [DATA_WIDTH-1:0] io_dq
);

  logic                  r_oe;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Enable, drive data and sampled data all come straight from flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_oe    <= 1'b0;
      r_dout  <= '0;
      r_rdata <= '0;
    end else begin
      r_oe <= i_oe_d;
      if (i_load)   r_dout  <= i_wdata;
      if (i_sample) r_rdata <= io_dq;
    end
  end

  assign io_dq   = r_oe ? r_dout : {DATA_WIDTH{1'bz}};
  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous controller for an external asynchronous SRAM.
// Bus side: single-outstanding req/ready with a one-cycle ack pulse.
// Pin side: registered CE_n/OE_n/WE_n/byte-lane strobes, tri-state data.
//   clk, reset_n    : clock, async active-low reset
//   req/we/addr/wdata/be : request, held until accepted (req & ready)
//   ready           : idle, request accepted on this edge
//   ack             : one-cycle completion pulse
//   rdata           : read data, valid in ack cycle, held until next read
//   sram_addr/dq/ce_n/oe_n/we_n/be_n : SRAM pins
module sram_ctrl
  import sram_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 20,
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned READ_WAIT  = 2,
  parameter  int unsigned WRITE_WAIT = 2,
  parameter  int unsigned TURN       = 1,
  localparam int unsigned LANES      = lanes_f(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [LANES-1:0]      be,
  output logic                  ready,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_dq,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [LANES-1:0]      sram_be_n
);

  localparam int unsigned CNT_W = cnt_width_f(READ_WAIT, WRITE_WAIT, TURN);
  localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'((TURN > 0) ? TURN - 1 : 0);
  localparam bit               HAS_TURN = (TURN > 0);

  // Reject illegal configurations at elaboration
  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("sram_ctrl: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_WAIT < 1) begin : g_bad_rw
    $error("sram_ctrl: READ_WAIT must be >= 1");
  end
  if (WRITE_WAIT < 1) begin : g_bad_ww
    $error("sram_ctrl: WRITE_WAIT must be >= 1");
  end

  state_e            r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [LANES-1:0]  r_be, w_be_cur;
  logic              r_last_rd;
  logic              r_ready, r_ack, r_ce_n, r_oe_n, r_we_n;
  logic [LANES-1:0]  r_be_n;
  logic [ADDR_WIDTH-1:0] r_sram_addr;

  logic              w_accept, w_sample;
  logic              w_ce_n_d, w_oe_n_d, w_we_n_d, w_dq_oe_d, w_ack_d, w_ready_d;
  logic [LANES-1:0]  w_be_n_d;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_accept = req & r_ready;

  // State and wait-counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state, counter reload on state entry, and next-cycle pin values
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_sample     = 1'b0;
    w_be_cur     = w_accept ? be : r_be;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!we) begin
            w_next_state = ST_RD;
            w_cnt_next   = RD_LD;
          end else if (be == '0) begin
            w_next_state = ST_DONE;
          end else if (r_last_rd && HAS_TURN) begin
            w_next_state = ST_TURN;
            w_cnt_next   = TURN_LD;
          end else begin
            w_next_state = ST_WR_SETUP;
          end
        end
      end
      ST_RD: begin
        if (r_cnt == '0) begin
          w_next_state = ST_DONE;
          w_sample     = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_TURN: begin
        if (r_cnt == '0) w_next_state = ST_WR_SETUP;
        else             w_cnt_next   = r_cnt - CNT_W'(1);
      end
      ST_WR_SETUP: begin
        w_next_state = ST_WR_PULSE;
        w_cnt_next   = WR_LD;
      end
      ST_WR_PULSE: begin
        if (r_cnt == '0) w_next_state = ST_WR_HOLD;
        else             w_cnt_next   = r_cnt - CNT_W'(1);
      end
      ST_WR_HOLD: w_next_state = ST_IDLE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase

    // Pin strobes are flopped from the next state so they never glitch
    w_ce_n_d  = !(w_next_state inside {ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
    w_oe_n_d  = (w_next_state != ST_RD);
    w_we_n_d  = (w_next_state != ST_WR_PULSE);
    w_dq_oe_d = (w_next_state inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
    w_ack_d   = (w_next_state inside {ST_DONE, ST_WR_HOLD});
    w_ready_d = (w_next_state == ST_IDLE);
    w_be_n_d  = '1;
    if (w_next_state == ST_RD) w_be_n_d = '0;
    else if (w_dq_oe_d)        w_be_n_d = ~w_be_cur;
  end

  // Request latches, turnaround history and strobe flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_be        <= '0;
      r_last_rd   <= 1'b0;
      r_sram_addr <= '0;
      r_ready     <= 1'b0;
      r_ack       <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_be_n      <= '1;
    end else begin
      if (w_accept) begin
        r_be        <= be;
        r_sram_addr <= addr;
        // A byte-less write never touches the bus, so it leaves history alone
        if (!we)            r_last_rd <= 1'b1;
        else if (be != '0)  r_last_rd <= 1'b0;
      end
      r_ready <= w_ready_d;
      r_ack   <= w_ack_d;
      r_ce_n  <= w_ce_n_d;
      r_oe_n  <= w_oe_n_d;
      r_we_n  <= w_we_n_d;
      r_be_n  <= w_be_n_d;
    end
  end

  sram_dq_pad #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pad (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_oe_d   (w_dq_oe_d),
    .i_load   (w_accept),
    .i_wdata  (wdata),
    .i_sample (w_sample),
    .o_rdata  (w_rdata),
    .io_dq    (sram_dq)
  );

  assign ready     = r_ready;
  assign ack       = r_ack;
  assign rdata     = w_rdata;
  assign sram_addr = r_sram_addr;
  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;
  assign sram_be_n = r_be_n;

endmodule
